// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU among four requesters
//            with registered ALU inputs and a valid/ready response return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         gnt,
  output logic [2:0]         alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  output logic [3:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  input  logic [3:0]         rsp_ready,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  logic             r_busy;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_rsp_data;

  logic [1:0]       w_winner;
  logic [1:0]       w_idx;
  logic             w_found;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // Search last+1 .. last+4 (mod 4); the final step revisits last itself.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_winner == 2'(i)) begin
        w_op = req_op[3*i +: 3];
        w_a  = req_a[WIDTH*i +: WIDTH];
        w_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_onehot
      assign gnt[i]       = (r_state == S_IDLE) && w_found && (w_winner == 2'(i));
      assign rsp_valid[i] = (r_state == S_RESP) && (r_owner == 2'(i));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 2'd3;
      r_owner    <= 2'd0;
      r_busy     <= 1'b0;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_alu_op <= w_op;
            r_alu_a  <= w_a;
            r_alu_b  <= w_b;
            r_owner  <= w_winner;
            r_last   <= w_winner;
            r_state  <= S_ISSUE;
            r_busy   <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_rsp_data <= alu_result;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's ready bit can retire the response.
          if (rsp_ready[r_owner]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op   = r_alu_op;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign rsp_data = r_rsp_data;
  assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed scoreboard bench for alu_share_arbiter with an 8-op ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        req = '0;
  logic [11:0]       req_op = '0;
  logic [4*WIDTH-1:0] req_a = '0;
  logic [4*WIDTH-1:0] req_b = '0;
  logic [3:0]        gnt;
  logic [2:0]        alu_op;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;
  logic [3:0]        rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic [3:0]        rsp_ready = '0;
  logic              busy;

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU model: 2 = add as the single-request case expects.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a & alu_b;
      3'd1:    alu_result = alu_a | alu_b;
      3'd2:    alu_result = alu_a + alu_b;
      3'd3:    alu_result = alu_a - alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_a << alu_b[4:0];
      3'd6:    alu_result = alu_a >> alu_b[4:0];
      default: alu_result = ~alu_a;
    endcase
  end

  typedef struct {
    logic [3:0]       owner;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req_v);
    end
  endtask

  // Response monitor: pops one expectation per completed handshake.
  always @(negedge clk) begin
    if (rst_n && ((rsp_valid & rsp_ready) != 4'b0)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {28'b0, rsp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_owner", {28'b0, rsp_valid}, {28'b0, e.owner});
        check("rsp_data", rsp_data, e.data);
      end
    end
    if (rst_n && gnt != 4'b0) check("gnt_while_busy", {31'b0, busy}, 32'h0);
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_op[3*i +: 3]        = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic push(input logic [3:0] owner, input logic [WIDTH-1:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0;
    rsp_ready = '0;
    exp_q.delete();
    @(negedge clk);
    check("rst_gnt", {28'b0, gnt}, 32'h0);
    check("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_alu_op", {29'b0, alu_op}, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input logic [3:0] expv, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 20);
    if (gnt == 4'b0) check({nm, "_timeout"}, 32'h0, {28'b0, expv});
    else             check(nm, {28'b0, gnt}, {28'b0, expv});
    gnt_cyc = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("drain_timeout", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;

    // Single request after reset
    do_reset();
    set_req(0, 3'd2, 32'd5, 32'd7);
    rsp_ready = 4'b1111;
    req = 4'b0001;
    push(4'b0001, 32'd12);
    @(negedge clk);
    check("single_gnt", {28'b0, gnt}, 32'h1);
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    check("single_alu_op", {29'b0, alu_op}, 32'd2);
    check("single_alu_a", alu_a, 32'd5);
    check("single_alu_b", alu_b, 32'd7);
    check("single_busy_t1", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("single_rsp_valid", {28'b0, rsp_valid}, 32'h1);
    check("single_rsp_data", rsp_data, 32'd12);
    @(negedge clk);
    check("single_busy_t3", {31'b0, busy}, 32'h0);

    // Full contention
    do_reset();
    set_req(0, 3'd3, 32'd100, 32'd1);
    set_req(1, 3'd0, 32'h0000F0F0, 32'h0000FF00);
    set_req(2, 3'd4, 32'h0000AAAA, 32'h00005555);
    set_req(3, 3'd7, 32'h00000000, 32'h12345678);
    push(4'b0001, 32'd99);
    push(4'b0010, 32'h0000F000);
    push(4'b0100, 32'h0000FFFF);
    push(4'b1000, 32'hFFFFFFFF);
    rsp_ready = 4'b1111;
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(4'(1 << k), "contend_gnt");
      if (k > 0) check("contend_spacing", gnt_cyc - prev, 32'd3);
      prev = gnt_cyc;
      @(posedge clk); #1;
      req[k] = 1'b0;
    end
    drain();

    // Fairness between requesters 0 and 3
    do_reset();
    set_req(0, 3'd1, 32'h0F, 32'hF0);
    set_req(3, 3'd5, 32'd1, 32'd4);
    push(4'b0001, 32'hFF);
    push(4'b1000, 32'd16);
    push(4'b0001, 32'hFF);
    push(4'b1000, 32'd16);
    rsp_ready = 4'b1111;
    req = 4'b1001;
    wait_gnt(4'b0001, "fair_gnt0");
    wait_gnt(4'b1000, "fair_gnt1");
    wait_gnt(4'b0001, "fair_gnt2");
    wait_gnt(4'b1000, "fair_gnt3");
    @(posedge clk); #1;
    req = 4'b0000;
    drain();

    // Backpressure on requester 1 with requester 2 waiting
    do_reset();
    set_req(1, 3'd2, 32'd1000, 32'd234);
    set_req(2, 3'd6, 32'h100, 32'd4);
    push(4'b0010, 32'd1234);
    push(4'b0100, 32'h10);
    rsp_ready = 4'b0000;
    req = 4'b0110;
    wait_gnt(4'b0010, "bp_gnt1");
    @(posedge clk); #1;
    req = 4'b0100;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", {28'b0, rsp_valid}, 32'h2);
      check("bp_rsp_data", rsp_data, 32'd1234);
      check("bp_busy", {31'b0, busy}, 32'h1);
      check("bp_gnt", {28'b0, gnt}, 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("bp_gnt2", {28'b0, gnt}, 32'h4);
    check("bp_idle", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    req = 4'b0000;
    rsp_ready = 4'b1111;
    drain();

    // Asynchronous reset while in RESP
    do_reset();
    set_req(0, 3'd2, 32'd3, 32'd4);
    rsp_ready = 4'b0000;
    req = 4'b0001;
    wait_gnt(4'b0001, "rr_gnt");
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("rr_valid_before", {28'b0, rsp_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_valid_async", {28'b0, rsp_valid}, 32'h0);
    check("rr_busy_async", {31'b0, busy}, 32'h0);
    check("rr_alu_a_async", alu_a, 32'h0);
    check("rr_data_async", rsp_data, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1, 3'd1, 32'h30, 32'h0C);
    set_req(2, 3'd0, 32'hFF, 32'h0F);
    push(4'b0010, 32'h3C);
    push(4'b0100, 32'h0F);
    rsp_ready = 4'b1111;
    req = 4'b0110;
    wait_gnt(4'b0010, "rr_first_gnt");
    @(posedge clk); #1;
    req = 4'b0100;
    wait_gnt(4'b0100, "rr_second_gnt");
    @(posedge clk); #1;
    req = 4'b0000;
    drain();

    // Non-owner ready bits are ignored
    do_reset();
    set_req(2, 3'd3, 32'd50, 32'd8);
    push(4'b0100, 32'd42);
    rsp_ready = 4'b1011;
    req = 4'b0100;
    wait_gnt(4'b0100, "no_gnt");
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_rsp_valid", {28'b0, rsp_valid}, 32'h4);
      check("no_busy", {31'b0, busy}, 32'h1);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("no_idle", {31'b0, busy}, 32'h0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
